multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Iterative MIPS multiply/divide unit, directly downstream of the register file.
- Consumes the two register read ports (rs, rt) for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers.
- Supports MTHI/MTLO writes; HI/LO outputs feed the MFHI/MFLO path.
- Issue stage must stall dependent instructions while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  issue request for a mult/div op; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  input  WIDTH  multiplicand / dividend (register read port 1)
- rt_data  input  WIDTH  multiplier / divisor (register read port 2)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO just updated by a mult/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst=1 at an edge) forces:
  - state IDLE; busy=0, done=0, hi=0, lo=0.
  - Applies from any state; an in-flight operation is discarded and HI/LO are not written.
- States: IDLE -> LOAD -> ITER (32 cycles) -> FIX -> IDLE.
- IDLE:
  - On start=1, latch op, rs_data, rt_data.
  - For signed ops, record the signs and convert the operands to magnitudes.
  - Go to LOAD.
  - busy rises after the start edge.
- LOAD: initialise the 64-bit accumulator / partial remainder and a 5-bit iteration counter; go to ITER.
- ITER: one shift-add (mult) or restoring shift-subtract (div) step per cycle; the counter counts 0..31 and leaves at 31.
- FIX:
  - Apply signs.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - Write {hi,lo} = product; or lo = quotient, hi = remainder.
  - Go to IDLE.
- Latency:
  - start sampled at edge t; HI/LO valid after edge t+34.
  - busy=1 from edge t+1 through edge t+34; done=1 for exactly the cycle following edge t+34.
- Divide by zero (rt=0): hi = rs_data unmodified; lo = 32'hFFFF_FFFF; same latency; signed and unsigned alike.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0; no trap.
- start while busy: ignored, no queuing.
- mthi/mtlo while busy: ignored.
- mthi/mtlo in IDLE: write on that edge, visible next cycle. Both may assert together, writing HI and LO.
- start together with mthi/mtlo in IDLE: start wins; the MT write is dropped.
- rs_data/rt_data changes after the start edge have no effect.
- hi/lo change only at FIX, at an accepted MT write, or at reset.

Decomposition:
- Package multdiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state encodings S_IDLE/S_LOAD/S_ITER/S_FIX
  - ITER_COUNT=32
  - DIV0_LO=32'hFFFF_FFFF
- One sub-module, multdiv_signfix: combinational sign restoration for the 64-bit product and for quotient/remainder.
- FSM, datapath and HI/LO registers stay in multdiv_unit.

Test Plan:
- MULTU rs=0xFFFF_FFFF rt=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; done exactly 35 cycles after start, busy high for 34 cycles.
- MULT rs=0xFFFF_FFFD (-3) rt=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; DIVU rs=100 rt=7 -> lo=14, hi=2.
- DIV rs=0xFFFF_FFF9 (-7) rt=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIV rs=0x8000_0000 rt=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIV rs=0x1234_5678 rt=0 -> hi=0x1234_5678, lo=0xFFFF_FFFF, normal latency.
- Second start and mthi(wdata=0xAAAA_AAAA) pulsed mid-operation -> both ignored, first result only, single done; then mtlo wdata=0x5555_5555 in IDLE -> lo=0x5555_5555 next cycle, hi unchanged.
- rst asserted 10 cycles into a MULTU -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows; a fresh start completes normally.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared encodings and constants for the iterative MIPS multiply/divide unit.
package multdiv_pkg;

  // Operation select as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states: capture, accumulator init, iterate, sign fix-up.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_ITER = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  // LO value produced by a divide whose divisor is zero.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  // True for the two's-complement variants that need magnitude conversion.
  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_signfix.sv
// Combinational sign restoration: the core iterates on magnitudes, this block
// turns the raw accumulator back into signed HI/LO values.
module multdiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Multiply negates the whole 64-bit product; divide fixes quotient and remainder independently.
  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      hi = rem;
      lo = quot;
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes,
// signs reapplied in the FIX state.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     rs_raw_q, rs_raw_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH:0]     div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  multdiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_div  (is_div_q),
    .neg_res (neg_res_q),
    .neg_rem (neg_rem_q),
    .acc     (acc_q),
    .hi      (fix_hi),
    .lo      (fix_lo)
  );

  // One iteration step of each algorithm; a non-negative trial difference sets the quotient bit.
  always_comb begin
    sign_a    = is_signed_op(op_e'(op)) & rs_data[WIDTH-1];
    sign_b    = is_signed_op(op_e'(op)) & rt_data[WIDTH-1];
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, b_q};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    end else begin
      div_next = div_shift[2*WIDTH-1:0];
    end
  end

  // Sequencer, operand capture and HI/LO update.
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    a_d       = a_q;
    b_d       = b_q;
    rs_raw_d  = rs_raw_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = (rt_data == '0);
          a_d       = sign_a ? -rs_data : rs_data;
          b_d       = sign_b ? -rt_data : rt_data;
          rs_raw_d  = rs_data;
          state_d   = S_LOAD;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_LOAD: begin
        acc_d   = {{WIDTH{1'b0}}, (is_div_q ? a_q : b_q)};
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q && div0_q) begin
          hi_d = rs_raw_q;
          lo_d = DIV0_LO;
        end else begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight and clears HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rs_raw_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rs_raw_q  <= rs_raw_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, corner-case
// sequences, and random operations compared with a plain-arithmetic model.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  multdiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Architectural result computed directly from MIPS semantics with 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo);
    longint          sp, sq, sr;
    longint unsigned up;
    case (o)
      2'b00: begin
        sp  = longint'($signed(a)) * longint'($signed(b));
        mhi = sp[63:32];
        mlo = sp[31:0];
      end
      2'b01: begin
        up  = {32'b0, a} * {32'b0, b};
        mhi = up[63:32];
        mlo = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          mhi = a;
          mlo = 32'hFFFF_FFFF;
        end else begin
          sq  = longint'($signed(a)) / longint'($signed(b));
          sr  = longint'($signed(a)) % longint'($signed(b));
          mhi = sr[31:0];
          mlo = sq[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          mhi = a;
          mlo = 32'hFFFF_FFFF;
        end else begin
          mhi = a % b;
          mlo = a / b;
        end
      end
    endcase
  endfunction

  // Issue one operation and watch 40 cycles, tallying busy/done and optional disturbances.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit disturb, input bit mt_with_start,
                               output int busy_cnt, output int done_at, output int done_cnt,
                               output logic [31:0] lo_k1);
    @(negedge clk);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    if (mt_with_start) begin
      mtlo  = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    lo_k1    = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) begin
        lo_k1   = lo;
        start   = 1'b0;
        mtlo    = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
      end
      if (disturb && k == 10) begin
        start   = 1'b1;
        op      = OP_MULTU;
        rs_data = 32'hFFFF_FFFF;
        rt_data = 32'hFFFF_FFFF;
        mthi    = 1'b1;
        wdata   = 32'hAAAA_AAAA;
      end
      if (disturb && k == 11) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
    end
  endtask

  initial begin
    int          bc, da, dc;
    logic [31:0] lk1, ehi, elo, keep_hi;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wdata   = '0;

    vecs.push_back('{"multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_neg3x7", OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{"div_neg7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
    vecs.push_back('{"div_by0",     OP_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF});
    vecs.push_back('{"div_neg_by0", OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{"divu_by0",    OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{"mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
    vecs.push_back('{"div_7_neg2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // Directed vector table with latency checks
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0, bc, da, dc, lk1);
      checkOutput({vecs[i].name, " hi"}, 64'(hi), 64'(vecs[i].hi));
      checkOutput({vecs[i].name, " lo"}, 64'(lo), 64'(vecs[i].lo));
      checkOutput({vecs[i].name, " busy_cycles"}, 64'(bc), 64'd34);
      checkOutput({vecs[i].name, " done_cycle"}, 64'(da), 64'd35);
      checkOutput({vecs[i].name, " done_count"}, 64'(dc), 64'd1);
    end

    // Second start and mthi mid-operation are ignored
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, bc, da, dc, lk1);
    checkOutput("busy_start hi", 64'(hi), 64'd2);
    checkOutput("busy_start lo", 64'(lo), 64'd14);
    checkOutput("busy_start done_cycle", 64'(da), 64'd35);
    checkOutput("busy_start done_count", 64'(dc), 64'd1);

    // mtlo in IDLE visible next cycle, hi unchanged
    @(negedge clk);
    mtlo  = 1'b1;
    wdata = 32'h5555_5555;
    @(negedge clk);
    mtlo  = 1'b0;
    checkOutput("mtlo lo", 64'(lo), 64'h5555_5555);
    checkOutput("mtlo hi", 64'(hi), 64'd2);

    // mthi and mtlo together
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h1357_9BDF;
    @(negedge clk);
    mthi  = 1'b0;
    mtlo  = 1'b0;
    checkOutput("mt_both hi", 64'(hi), 64'h1357_9BDF);
    checkOutput("mt_both lo", 64'(lo), 64'h1357_9BDF);

    // start with mtlo: start wins, MT write dropped
    applyStimulus(OP_DIVU, 32'd9, 32'd2, 1'b0, 1'b1, bc, da, dc, lk1);
    checkOutput("start_mt lo_after_start", 64'(lk1), 64'h1357_9BDF);
    checkOutput("start_mt hi", 64'(hi), 64'd1);
    checkOutput("start_mt lo", 64'(lo), 64'd4);

    // Reset 10 cycles into a MULTU
    @(negedge clk);
    op      = OP_MULTU;
    rs_data = 32'hFFFF_FFFF;
    rt_data = 32'hFFFF_FFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst busy", 64'(busy), 64'd0);
    checkOutput("midrst done", 64'(done), 64'd0);
    checkOutput("midrst hi", 64'(hi), 64'd0);
    checkOutput("midrst lo", 64'(lo), 64'd0);
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    checkOutput("midrst quiet_cycles", 64'(dc), 64'd0);
    checkOutput("midrst hi_after", 64'(hi), 64'd0);
    applyStimulus(OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, bc, da, dc, lk1);
    checkOutput("postrst lo", 64'(lo), 64'd15);
    checkOutput("postrst hi", 64'(hi), 64'd0);
    checkOutput("postrst done_cycle", 64'(da), 64'd35);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 300));
      model(ro, ra, rb, ehi, elo);
      applyStimulus(ro, ra, rb, 1'b0, 1'b0, bc, da, dc, lk1);
      checkOutput($sformatf("rand%0d op%0d %h/%h hi", i, ro, ra, rb), 64'(hi), 64'(ehi));
      checkOutput($sformatf("rand%0d op%0d %h/%h lo", i, ro, ra, rb), 64'(lo), 64'(elo));
      checkOutput($sformatf("rand%0d done_cycle", i), 64'(da), 64'd35);
    end

    // hi/lo hold steady in IDLE with no write
    keep_hi = hi;
    repeat (5) @(negedge clk);
    checkOutput("idle hold hi", 64'(hi), 64'(keep_hi));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
